// File: rtl/sorted_search.sv
// Binary-search reader for a sorted 2^ADDR_W x DATA_W synchronous-read RAM.
// Define SORTED_SEARCH_FIRST_MATCH_EN to continue past a hit and report the lowest matching address.
module sorted_search #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] target,
    output logic [ADDR_W-1:0] addr,
    output logic              wren,
    input  logic [DATA_W-1:0] q,
    output logic              finish,
    output logic              found,
    output logic [ADDR_W-1:0] loc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PROBE = 2'd1;
    localparam logic [1:0] S_CMP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    logic [ADDR_W-1:0] mid;
    logic [ADDR_W:0]   mid_wide;
    logic [DATA_W-1:0] tgt;

    // Sum is taken one bit wider so lo+hi cannot overflow before halving.
    assign mid_wide = ({1'b0, lo} + {1'b0, hi}) >> 1;
    assign mid      = mid_wide[ADDR_W-1:0];

    // addr stays on mid through PROBE and CMP so q lines up with the CMP cycle.
    always_comb begin
        addr = '0;
        if (state == S_PROBE || state == S_CMP) begin
            addr = mid;
        end
    end

    assign wren   = 1'b0;
    assign finish = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            lo    <= '0;
            hi    <= '0;
            tgt   <= '0;
            found <= 1'b0;
            loc   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        tgt   <= target;
                        lo    <= '0;
                        hi    <= '1;
                        found <= 1'b0;
                        loc   <= '0;
                        state <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (q == tgt) begin
                        found <= 1'b1;
                        loc   <= mid;
`ifdef SORTED_SEARCH_FIRST_MATCH_EN
                        if (mid == lo) begin
                            state <= S_DONE;
                        end else begin
                            hi    <= mid - ADDR_W'(1);
                            state <= S_PROBE;
                        end
`else
                        state <= S_DONE;
`endif
                    end else if (q < tgt) begin
                        // mid==hi means the upper half is empty; lo never wraps past the top.
                        if (mid == hi) begin
                            state <= S_DONE;
                        end else begin
                            lo    <= mid + ADDR_W'(1);
                            state <= S_PROBE;
                        end
                    end else begin
                        if (mid == lo) begin
                            state <= S_DONE;
                        end else begin
                            hi    <= mid - ADDR_W'(1);
                            state <= S_PROBE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_search.sv
// Scoreboard bench for sorted_search: stimulus pushes predicted results, a negedge monitor checks them.
module tb_sorted_search;

    localparam int AW = 4;
    localparam int DW = 4;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] target;
    logic [AW-1:0] addr;
    logic          wren;
    logic [DW-1:0] q;
    logic          finish;
    logic          found;
    logic [AW-1:0] loc;

    logic [DW-1:0] mem [N];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        int    tgt;
        bit    f;
        int    loc;
        int    lat;
        int    ic;
        bit    hit;
        int    first;
        string name;
    } exp_t;

    exp_t sb[$];
    bit   prev_fin = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        q   <= mem[addr];
        cyc <= cyc + 1;
    end

    sorted_search #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .target(target),
        .addr  (addr),
        .wren  (wren),
        .q     (q),
        .finish(finish),
        .found (found),
        .loc   (loc)
    );

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Interval bisection over the current RAM image, plain integer arithmetic.
    function automatic void model(input int t, output bit f, output int l, output int p);
        int lo;
        int hi;
        int m;
        lo = 0;
        hi = N - 1;
        f  = 1'b0;
        l  = 0;
        p  = 0;
        for (int k = 0; k < 2 * AW + 4; k++) begin
            m = (lo + hi) / 2;
            p++;
            if (int'(mem[m]) == t) begin
                f = 1'b1;
                l = m;
`ifdef SORTED_SEARCH_FIRST_MATCH_EN
                if (m == lo) break;
                hi = m - 1;
`else
                break;
`endif
            end else if (int'(mem[m]) < t) begin
                if (m == hi) break;
                lo = m + 1;
            end else begin
                if (m == lo) break;
                hi = m - 1;
            end
        end
    endfunction

    task automatic issue(input int t, input string nm);
        exp_t e;
        e.tgt   = t;
        e.name  = nm;
        e.ic    = cyc;
        e.hit   = 1'b0;
        e.first = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (int'(mem[i]) == t) begin
                e.hit   = 1'b1;
                e.first = i;
            end
        end
        model(t, e.f, e.loc, e.lat);
        e.lat = 1 + 2 * e.lat;
        sb.push_back(e);
        start  = 1'b1;
        target = DW'(t);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            check("search_timeout", 1, 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("wren_low", int'(wren), 0);
            if (finish && !prev_fin) begin
                if (sb.size() == 0) begin
                    check("unexpected_finish", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_found"}, int'(found), int'(e.f));
                    check({e.name, "_loc"}, int'(loc), e.loc);
                    check({e.name, "_latency"}, cyc - e.ic, e.lat);
                    check({e.name, "_hit_vs_scan"}, int'(found), int'(e.hit));
                    check({e.name, "_addr_done"}, int'(addr), 0);
                    if (found) check({e.name, "_mem_at_loc"}, int'(mem[loc]), e.tgt);
`ifdef SORTED_SEARCH_FIRST_MATCH_EN
                    if (e.hit) check({e.name, "_lowest"}, int'(loc), e.first);
`endif
                    if (e.lat > 2 * (AW + 1) + 1) check({e.name, "_probe_bound"}, e.lat, 2 * (AW + 1) + 1);
                end
            end
        end
        prev_fin = finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int v[$];
        int rng;
        reset  = 1'b1;
        start  = 1'b0;
        target = '0;
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        repeat (2) @(posedge clk);
        #1;
        check("reset_finish", int'(finish), 0);
        check("reset_found", int'(found), 0);
        check("reset_loc", int'(loc), 0);
        check("reset_addr", int'(addr), 0);
        check("reset_wren", int'(wren), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(7, "mid_hit");
        wait_done();
        issue(0, "low_edge");
        wait_done();
        issue(15, "high_edge");
        wait_done();

        for (int i = 0; i < N; i++) mem[i] = DW'((2 * i > 15) ? 15 : 2 * i);
        issue(3, "absent_gap");
        wait_done();
        for (int i = 0; i < N; i++) mem[i] = DW'((i + 1 > 15) ? 15 : i + 1);
        issue(0, "below_min");
        wait_done();

        for (int i = 0; i < N; i++) mem[i] = DW'(5);
        issue(5, "all_dup");
        wait_done();

        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        issue(4, "reset_victim");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_finish", int'(finish), 0);
        check("midreset_found", int'(found), 0);
        check("midreset_addr", int'(addr), 0);
        reset = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("after_reset_idle", int'(finish), 0);
        issue(9, "post_reset");
        wait_done();

        issue(12, "restart_done");
        check("restart_finish_drop", int'(finish), 0);
        wait_done();

        issue(3, "ignore_busy_start");
        start  = 1'b1;
        target = DW'(10);
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        for (int n = 0; n < 80; n++) begin
            v.delete();
            rng = $urandom_range(15, 1);
            for (int i = 0; i < N; i++) v.push_back($urandom_range(rng, 0));
            v.sort();
            for (int i = 0; i < N; i++) mem[i] = DW'(v[i]);
            issue($urandom_range(15, 0), "random");
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
